// File: rtl/lsu_if.sv
// Memory-side bus between the load/store unit and the data memory.
// The LSU drives the request fields; the memory returns ready and read data.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage request into a single memory access,
// aligning and extending load data and flagging misaligned/illegal accesses.
//
// state | meaning
// IDLE  | waiting for start; request fields captured on accept
// REQ   | memory request held stable until mem_ready
// RESP  | one-cycle done with load result / write-back
// ERR   | one-cycle done with fault, no memory access made
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic        wb_en,
  output logic        fault,
  lsu_if.master       mem
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;

  logic        legal;
  logic        misaligned;
  logic [31:0] lane_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    legal = 1'b0;
    if (opcode == OP_LOAD)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    else if (opcode == OP_STORE)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal && !misaligned) begin
            state_d      = REQ;
            is_store_d   = (opcode == OP_STORE);
            funct3_d     = funct3;
            addr_d       = addr;
            store_data_d = store_data;
            rd_d         = rd;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          rdata_d = mem.mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      rd_q         <= 5'd0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
    end
  end

  // Lane extraction works off the registered word and captured address only.
  always_comb begin
    lane_shift = rdata_q >> {addr_q[1:0], 3'b000};
    lane_byte  = lane_shift[7:0];
    lane_half  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    busy          = (state_q != IDLE);
    done          = 1'b0;
    load_data     = 32'h0;
    rd_out        = 5'd0;
    wb_en         = 1'b0;
    fault         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'h0;
    mem.mem_wstrb = 4'b0000;
    mem.mem_wdata = 32'h0;
    case (state_q)
      REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = is_store_q;
        mem.mem_addr = {addr_q[31:2], 2'b00};
        if (is_store_q) begin
          case (funct3_q[1:0])
            2'b00: begin
              mem.mem_wstrb = 4'b0001 << addr_q[1:0];
              mem.mem_wdata = {4{store_data_q[7:0]}};
            end
            2'b01: begin
              mem.mem_wstrb = 4'b0011 << addr_q[1:0];
              mem.mem_wdata = {2{store_data_q[15:0]}};
            end
            default: begin
              mem.mem_wstrb = 4'b1111;
              mem.mem_wdata = store_data_q;
            end
          endcase
        end
      end
      RESP: begin
        done   = 1'b1;
        rd_out = rd_q;
        if (!is_store_q) begin
          wb_en = (rd_q != 5'd0);
          case (funct3_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'h0, lane_byte};
            3'b101:  load_data = {16'h0, lane_half};
            default: load_data = rdata_q;
          endcase
        end
      end
      ERR: begin
        done  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
